// File: rtl/pic_frame_ctrl.sv
//------------------------------------------------------------------------------
// pic_frame_ctrl
//   Frame-level controller behind the serial byte decoder. Hunts for a sync
//   byte, collects a fixed-length frame with an inter-byte timeout, verifies
//   an 8-bit additive checksum and publishes good frames via a ping-pong
//   buffer that the host reads and acknowledges.
//   Optional statistics counters: define PIC_FRAME_STATS_EN.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pic_frame_ctrl #(
  parameter int unsigned FRAME_LEN   = 8,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYC = 16'd40000
) (
  input  logic        clock_system,
  input  logic        Rst,
  input  logic        ctrl_en,
  input  logic [7:0]  recv_data_m2,
  input  logic        recv_data_m2_finish,
  output logic        frame_valid,
  input  logic [3:0]  frame_rd_addr,
  output logic [7:0]  frame_rd_data,
  input  logic        frame_ack,
  output logic        busy,
  output logic        err_sync,
  output logic        err_timeout,
  output logic        err_csum,
  output logic        err_overrun,
  output logic [15:0] frame_good_cnt,
  output logic [15:0] frame_err_cnt
);

  localparam int unsigned IW       = $clog2(FRAME_LEN);
  localparam logic [3:0]  LAST_IDX = 4'(FRAME_LEN - 1);
  localparam logic [15:0] TMO_LAST = TIMEOUT_CYC - 16'd1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_HUNT    = 4'b0010,
    ST_COLLECT = 4'b0100,
    ST_CHECK   = 4'b1000
  } state_t;

  state_t                          state_q;
  logic [1:0][FRAME_LEN-1:0][7:0]  bank_q;
  logic                            bank_sel_q;   // bank currently published
  logic [3:0]                      idx_q;
  logic [15:0]                     timeout_q;
  logic [7:0]                      csum_q;
  logic [7:0]                      rx_csum_q;
  logic                            frame_valid_q;
  logic                            busy_q;
  logic                            err_sync_q;
  logic                            err_timeout_q;
  logic                            err_csum_q;
  logic                            err_overrun_q;

  logic w_work;
  logic w_csum_ok;
  logic w_valid_eff;
  logic w_publish;

  // The work bank is always the one not shown to the host.
  assign w_work      = ~bank_sel_q;
  assign w_csum_ok   = (csum_q == rx_csum_q);
  // An ack arriving together with the check frees the buffer for this frame.
  assign w_valid_eff = frame_valid_q & ~frame_ack;
  assign w_publish   = (state_q == ST_CHECK) & ctrl_en & w_csum_ok & ~w_valid_eff;

  // Frame state machine, ping-pong buffer and registered error pulses.
  always_ff @(posedge clock_system or negedge Rst) begin
    if (!Rst) begin
      state_q       <= ST_IDLE;
      bank_q        <= '0;
      bank_sel_q    <= 1'b0;
      idx_q         <= 4'd0;
      timeout_q     <= 16'd0;
      csum_q        <= 8'h00;
      rx_csum_q     <= 8'h00;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_sync_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_csum_q    <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      err_sync_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_csum_q    <= 1'b0;
      err_overrun_q <= 1'b0;

      // Ack releases the frame; a publish later in this block overrides it.
      if (frame_ack) begin
        frame_valid_q <= 1'b0;
      end

      if (!ctrl_en) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_HUNT;
            busy_q  <= 1'b0;
          end

          ST_HUNT: begin
            if (recv_data_m2_finish) begin
              if (recv_data_m2 == SYNC_BYTE) begin
                bank_q[w_work][0] <= recv_data_m2;
                csum_q            <= recv_data_m2;
                idx_q             <= 4'd1;
                timeout_q         <= 16'd0;
                state_q           <= ST_COLLECT;
                busy_q            <= 1'b1;
              end else begin
                err_sync_q <= 1'b1;
              end
            end
          end

          ST_COLLECT: begin
            if (recv_data_m2_finish) begin
              bank_q[w_work][idx_q[IW-1:0]] <= recv_data_m2;
              timeout_q                     <= 16'd0;
              if (idx_q == LAST_IDX) begin
                rx_csum_q <= recv_data_m2;
                state_q   <= ST_CHECK;
              end else begin
                csum_q <= csum_q + recv_data_m2;
                idx_q  <= idx_q + 4'd1;
              end
            end else if (timeout_q == TMO_LAST) begin
              err_timeout_q <= 1'b1;
              state_q       <= ST_HUNT;
              busy_q        <= 1'b0;
            end else begin
              timeout_q <= timeout_q + 16'd1;
            end
          end

          ST_CHECK: begin
            state_q <= ST_HUNT;
            busy_q  <= 1'b0;
            if (w_publish) begin
              bank_sel_q    <= w_work;
              frame_valid_q <= 1'b1;
            end else if (w_csum_ok) begin
              err_overrun_q <= 1'b1;
            end else begin
              err_csum_q <= 1'b1;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Host read port: published bank, zero outside the frame.
  always_comb begin
    frame_rd_data = 8'h00;
    if (frame_rd_addr <= LAST_IDX) begin
      frame_rd_data = bank_q[bank_sel_q][frame_rd_addr[IW-1:0]];
    end
  end

  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;
  assign err_sync    = err_sync_q;
  assign err_timeout = err_timeout_q;
  assign err_csum    = err_csum_q;
  assign err_overrun = err_overrun_q;

`ifdef PIC_FRAME_STATS_EN
  logic [15:0] good_cnt_q;
  logic [15:0] err_cnt_q;
  logic        w_any_err;

  assign w_any_err = err_sync_q | err_timeout_q | err_csum_q | err_overrun_q;

  // Saturating good-frame and error-event counters.
  always_ff @(posedge clock_system or negedge Rst) begin
    if (!Rst) begin
      good_cnt_q <= 16'h0000;
      err_cnt_q  <= 16'h0000;
    end else begin
      if (w_publish && (good_cnt_q != 16'hFFFF)) begin
        good_cnt_q <= good_cnt_q + 16'd1;
      end
      if (w_any_err && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign frame_good_cnt = good_cnt_q;
  assign frame_err_cnt  = err_cnt_q;
`else
  assign frame_good_cnt = 16'h0000;
  assign frame_err_cnt  = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pic_frame_ctrl.sv
//------------------------------------------------------------------------------
// tb_pic_frame_ctrl
//   Directed plus randomized frames against a frame-level reference model.
//------------------------------------------------------------------------------
`default_nettype none

module tb_pic_frame_ctrl;

  localparam int FL = 4;
`ifdef PIC_FRAME_STATS_EN
  localparam logic [15:0] TMO = 16'd4000;
`else
  localparam logic [15:0] TMO = 16'd40000;
`endif

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic        ctrl_en = 1'b0;
  logic [7:0]  recv_data = 8'h00;
  logic        fin = 1'b0;
  logic        frame_valid;
  logic [3:0]  rd_addr = 4'd0;
  logic [7:0]  rd_data;
  logic        frame_ack = 1'b0;
  logic        busy;
  logic        err_sync, err_timeout, err_csum, err_overrun;
  logic [15:0] good_cnt, err_cnt;

  pic_frame_ctrl #(
    .FRAME_LEN  (FL),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clock_system       (clk),
    .Rst                (Rst),
    .ctrl_en            (ctrl_en),
    .recv_data_m2       (recv_data),
    .recv_data_m2_finish(fin),
    .frame_valid        (frame_valid),
    .frame_rd_addr      (rd_addr),
    .frame_rd_data      (rd_data),
    .frame_ack          (frame_ack),
    .busy               (busy),
    .err_sync           (err_sync),
    .err_timeout        (err_timeout),
    .err_csum           (err_csum),
    .err_overrun        (err_overrun),
    .frame_good_cnt     (good_cnt),
    .frame_err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observed pulse counts
  int n_sync = 0, n_tmo = 0, n_csum = 0, n_ovr = 0;
  always @(posedge clk) begin
    if (Rst) begin
      if (err_sync)    n_sync++;
      if (err_timeout) n_tmo++;
      if (err_csum)    n_csum++;
      if (err_overrun) n_ovr++;
    end
  end

  // Reference model state
  int         exp_sync = 0, exp_tmo = 0, exp_csum = 0, exp_ovr = 0, exp_good = 0;
  logic [7:0] pub [FL];
  bit         mvalid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    recv_data = b;
    fin       = 1'b1;
    tick();
    fin       = 1'b0;
  endtask

  task automatic check_reads(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk(tag, {24'd0, rd_data}, (a < FL) ? {24'd0, pub[a]} : 32'd0);
    end
    rd_addr = 4'd0;
  endtask

  task automatic check_errs(input string tag);
    int tot;
    idle(2);
    chk({tag, "_sync"},  n_sync, exp_sync);
    chk({tag, "_tmo"},   n_tmo,  exp_tmo);
    chk({tag, "_csum"},  n_csum, exp_csum);
    chk({tag, "_ovr"},   n_ovr,  exp_ovr);
    chk({tag, "_valid"}, {31'd0, frame_valid}, {31'd0, mvalid});
    tot = exp_sync + exp_tmo + exp_csum + exp_ovr;
`ifdef PIC_FRAME_STATS_EN
    chk({tag, "_goodcnt"}, {16'd0, good_cnt}, (exp_good > 65535) ? 32'hFFFF : exp_good);
    chk({tag, "_errcnt"},  {16'd0, err_cnt},  (tot > 65535) ? 32'hFFFF : tot);
`else
    chk({tag, "_goodcnt"}, {16'd0, good_cnt}, 32'd0);
    chk({tag, "_errcnt"},  {16'd0, err_cnt},  {16'd0, 16'(tot & 0)});
`endif
  endtask

  // Final byte lands; check the one-cycle CHECK state and the outcome.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input bit ack_chk, input int gap);
    logic [7:0] sum;
    bit good;
    send_byte(b0);
    chk("busy_collect", {31'd0, busy}, 32'd1);
    idle(gap - 1);
    send_byte(b1);
    idle(gap - 1);
    send_byte(b2);
    idle(gap - 1);
    send_byte(b3);
    chk("busy_check", {31'd0, busy}, 32'd1);
    chk("valid_in_check", {31'd0, frame_valid}, {31'd0, mvalid});
    sum  = b0 + b1 + b2;
    good = (sum == b3);
    frame_ack = ack_chk;
    if (good && !(mvalid && !ack_chk)) begin
      pub[0] = b0; pub[1] = b1; pub[2] = b2; pub[3] = b3;
      mvalid = 1;
      exp_good++;
    end else begin
      if (good) exp_ovr++;
      else      exp_csum++;
      if (ack_chk) mvalid = 0;
    end
    tick();
    frame_ack = 1'b0;
    chk("valid_after_check", {31'd0, frame_valid}, {31'd0, mvalid});
    chk("busy_after_check", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    mvalid = 0;
  endtask

  initial begin
    for (int i = 0; i < FL; i++) pub[i] = 8'h00;

    // Reset state
    idle(3);
    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_errs",  {28'd0, err_sync, err_timeout, err_csum, err_overrun}, 32'd0);
    chk("rst_cnts",  {good_cnt, err_cnt}, 32'd0);
    check_reads("rst_rd");
    Rst = 1'b1;
    ctrl_en = 1'b1;
    idle(2);

    // Basic good frame
    send_frame(8'hA5, 8'h01, 8'h02, 8'hA8, 1'b0, 13);
    check_reads("good1_rd");
    check_errs("good1");

    // Junk byte then bad checksum
    do_ack();
    send_byte(8'h3C); exp_sync++;
    idle(3);
    send_frame(8'hA5, 8'h10, 8'h20, 8'h00, 1'b0, 4);
    check_errs("badcsum");

    // Inter-byte timeout exactly TMO clocks after the last strobe
    send_byte(8'hA5);
    idle(2);
    send_byte(8'h01);
    idle(int'(TMO) - 1);
    chk("tmo_early", {31'd0, err_timeout}, 32'd0);
    chk("tmo_busy_early", {31'd0, busy}, 32'd1);
    tick();
    chk("tmo_pulse", {31'd0, err_timeout}, 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    exp_tmo++;
    send_frame(8'hA5, 8'h01, 8'h02, 8'hA8, 1'b0, 3);
    check_errs("tmo");

    // Strobe at the timeout boundary wins; frame is good but buffer full
    send_byte(8'hA5);
    idle(int'(TMO) - 1);
    send_byte(8'h02);
    chk("tmo_bound_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h02);
    send_byte(8'hA9);
    exp_ovr++;
    idle(1);
    rd_addr = 4'd3; #1;
    chk("ovr_rd3", {24'd0, rd_data}, 32'h0000_00A8);
    check_errs("ovr");

    // Ack together with publish
    send_frame(8'hA5, 8'h03, 8'h04, 8'hAC, 1'b1, 2);
    check_reads("ackpub_rd");
    check_errs("ackpub");

    // ctrl_en drop mid-frame
    do_ack();
    send_byte(8'hA5);
    send_byte(8'h11);
    ctrl_en = 1'b0;
    tick();
    chk("dis_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h22);
    idle(3);
    ctrl_en = 1'b1;
    idle(2);
    check_errs("dis");
    send_frame(8'hA5, 8'h05, 8'h06, 8'hB0, 1'b0, 2);
    check_reads("reen_rd");
    check_errs("reen");

    // Randomized frames
    for (int it = 0; it < 24; it++) begin
      logic [7:0] r1, r2, c, j;
      if ($urandom_range(0, 3) == 0) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h5A;
        send_byte(j);
        exp_sync++;
        idle($urandom_range(1, 5));
      end
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      c  = 8'hA5 + r1 + r2;
      if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
      send_frame(8'hA5, r1, r2, c, ($urandom_range(0, 4) == 0), $urandom_range(1, 20));
      idle(2);
      if ($urandom_range(0, 1) == 0) do_ack();
      check_reads("rand_rd");
      check_errs("rand");
    end

`ifdef PIC_FRAME_STATS_EN
    // Error counter saturation
    recv_data = 8'h00;
    fin = 1'b1;
    repeat (65540) tick();
    fin = 1'b0;
    exp_sync += 65540;
    check_errs("sat");
`endif

    // Asynchronous reset mid-collect
    send_byte(8'hA5);
    send_byte(8'h01);
    rd_addr = 4'd0;
    #2;
    Rst = 1'b0;
    #1;
    chk("arst_busy",  {31'd0, busy}, 32'd0);
    chk("arst_valid", {31'd0, frame_valid}, 32'd0);
    chk("arst_rd",    {24'd0, rd_data}, 32'd0);
    chk("arst_cnts",  {good_cnt, err_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
